in1536_out128: RTL and testbench



---
 rtl/in1536_out128_if.sv | 20 ++
 rtl/in1536_out128.sv | 91 +++++++++
 tb/tb_in1536_out128.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/in1536_out128_if.sv
// ============================================================================
// in1536_out128_if : AXI-Stream data/valid/ready/last bundle for the converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface in1536_out128_if #(
    parameter int DATA_W = 128,
    parameter int LAST_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic [LAST_W-1:0] tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/in1536_out128.sv
// ============================================================================
// in1536_out128 : 1536-to-128 AXI-Stream downsizer with per-lane tlast
// Rev 1.0
// ============================================================================
`default_nettype none

module in1536_out128 #(
    parameter int S_WIDTH = 1536,
    parameter int M_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    in1536_out128_if.slave         s_axis,
    in1536_out128_if.master        m_axis,
    output logic [M_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                   busy
);
    localparam int LANES = S_WIDTH / M_WIDTH;
    localparam int CNT_W = $clog2(LANES);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                          state_q;
    logic [LANES-1:0][M_WIDTH-1:0]   hold_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [CNT_W-1:0]                stop_q;
    logic                            last_flag_q;
    logic                            tvalid_q;

    logic [CNT_W-1:0]                stop_d;
    logic                            m_fire;
    logic                            last_lane;
    logic                            load;

    // Lowest set tlast bit ends the packet; an all-zero mask drains every lane.
    always_comb begin
        stop_d = CNT_W'(LANES - 1);
        for (int k = LANES - 1; k >= 0; k--) begin
            if (s_axis.tlast[k]) begin
                stop_d = CNT_W'(k);
            end
        end
    end

    assign m_fire       = tvalid_q & m_axis.tready;
    assign last_lane    = (cnt_q == stop_q);
    assign s_axis.tready = (state_q == EMPTY) | (m_fire & last_lane);
    assign load         = s_axis.tvalid & s_axis.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            tvalid_q    <= 1'b0;
            cnt_q       <= '0;
            stop_q      <= CNT_W'(LANES - 1);
            last_flag_q <= 1'b0;
        end else if (load) begin
            state_q     <= DRAIN;
            tvalid_q    <= 1'b1;
            cnt_q       <= '0;
            stop_q      <= stop_d;
            last_flag_q <= |s_axis.tlast;
        end else if (m_fire) begin
            if (last_lane) begin
                state_q  <= EMPTY;
                tvalid_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Data path needs no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            hold_q <= s_axis.tdata;
        end
    end

    assign m_axis.tdata  = hold_q[cnt_q];
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = last_lane & last_flag_q;
    assign m_axis_tkeep  = '1;
    assign busy          = tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_in1536_out128.sv
// ============================================================================
// tb_in1536_out128 : directed self-checking bench for the 1536-to-128 downsizer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_in1536_out128;
    logic        clk;
    logic        rst_n;
    logic [15:0] tkeep;
    logic        busy;
    int          n_checks;
    int          n_fail;

    in1536_out128_if #(.DATA_W(1536), .LAST_W(12)) s_if ();
    in1536_out128_if #(.DATA_W(128),  .LAST_W(1))  m_if ();

    in1536_out128 #(.S_WIDTH(1536), .M_WIDTH(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .m_axis_tkeep (tkeep),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1535:0] mk_beat(input int base);
        logic [1535:0] b;
        for (int k = 0; k < 12; k++) b[k*128 +: 128] = 128'(base + k);
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = '0;
        m_if.tready = 1'b0;
        #2;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %0b want 0", m_if.tvalid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready got %0b want 1", s_if.tready); end
        n_checks++;
        if (tkeep !== 16'hffff) begin n_fail++; $display("FAIL reset_tkeep got %0h want ffff", tkeep); end
    endtask

    task automatic test_no_last();
        @(negedge clk);
        s_if.tvalid = 1'b1; s_if.tdata = mk_beat(1); s_if.tlast = 12'h000; m_if.tready = 1'b1;
        #1;
        n_checks++;
        if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL nolast_accept got %0b want 1", s_if.tready); end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL nolast_valid beat %0d got %0b want 1", i, m_if.tvalid); end
            n_checks++;
            if (m_if.tdata !== 128'(i + 1)) begin n_fail++; $display("FAIL nolast_data beat %0d got %0h want %0h", i, m_if.tdata, i + 1); end
            n_checks++;
            if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL nolast_tlast beat %0d got %0b want 0", i, m_if.tlast); end
            n_checks++;
            if (s_if.tready !== (i == 11)) begin n_fail++; $display("FAIL nolast_sready beat %0d got %0b want %0b", i, s_if.tready, i == 11); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL nolast_end_valid got %0b want 0", m_if.tvalid); end
    endtask

    task automatic test_stop_lane(input logic [11:0] tl);
        @(negedge clk);
        s_if.tvalid = 1'b1; s_if.tdata = mk_beat(16); s_if.tlast = tl; m_if.tready = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL stop_%0h_valid beat %0d got %0b want 1", tl, i, m_if.tvalid); end
            n_checks++;
            if (m_if.tdata !== 128'(16 + i)) begin n_fail++; $display("FAIL stop_%0h_data beat %0d got %0h want %0h", tl, i, m_if.tdata, 16 + i); end
            n_checks++;
            if (m_if.tlast !== (i == 4)) begin n_fail++; $display("FAIL stop_%0h_tlast beat %0d got %0b want %0b", tl, i, m_if.tlast, i == 4); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL stop_%0h_padding_emitted got tvalid %0b want 0", tl, m_if.tvalid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        s_if.tvalid = 1'b1; s_if.tdata = mk_beat(100); s_if.tlast = 12'h800; m_if.tready = 1'b1;
        #1;
        n_checks++;
        if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_a got %0b want 1", s_if.tready); end
        @(negedge clk);
        s_if.tdata = mk_beat(200);
        for (int o = 0; o < 24; o++) begin
            if (o == 12) s_if.tvalid = 1'b0;
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap out %0d got tvalid %0b want 1", o, m_if.tvalid); end
            n_checks++;
            if (m_if.tdata !== 128'(o < 12 ? 100 + o : 188 + o)) begin
                n_fail++; $display("FAIL b2b_data out %0d got %0h want %0h", o, m_if.tdata, o < 12 ? 100 + o : 188 + o);
            end
            n_checks++;
            if (m_if.tlast !== (o == 11 || o == 23)) begin n_fail++; $display("FAIL b2b_tlast out %0d got %0b want %0b", o, m_if.tlast, o == 11 || o == 23); end
            n_checks++;
            if (s_if.tready !== (o == 11 || o == 23)) begin n_fail++; $display("FAIL b2b_sready out %0d got %0b want %0b", o, s_if.tready, o == 11 || o == 23); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %0b want 0", m_if.tvalid); end
    endtask

    task automatic test_random_ready();
        int          src_beat = 0;
        int          exp_word = 0;
        int          cycles   = 0;
        logic        prev_stall = 1'b0;
        logic [127:0] prev_data = '0;
        s_if.tlast = 12'h800;
        while (exp_word < 1200 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            m_if.tready = 1'($urandom_range(0, 1));
            s_if.tvalid = (src_beat < 100);
            s_if.tdata  = mk_beat(src_beat * 12);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data) begin
                    n_fail++; $display("FAIL rand_stable got valid %0b data %0h want valid 1 data %0h", m_if.tvalid, m_if.tdata, prev_data);
                end
            end
            n_checks++;
            if (tkeep !== 16'hffff) begin n_fail++; $display("FAIL rand_tkeep got %0h want ffff", tkeep); end
            if (m_if.tvalid && m_if.tready) begin
                n_checks++;
                if (m_if.tdata !== 128'(exp_word)) begin n_fail++; $display("FAIL rand_data got %0h want %0h", m_if.tdata, exp_word); end
                n_checks++;
                if (m_if.tlast !== (exp_word % 12 == 11)) begin n_fail++; $display("FAIL rand_tlast word %0d got %0b want %0b", exp_word, m_if.tlast, exp_word % 12 == 11); end
                exp_word++;
            end
            if (s_if.tvalid && s_if.tready) src_beat++;
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
        end
        n_checks++;
        if (exp_word != 1200) begin n_fail++; $display("FAIL rand_timeout got %0d words want 1200", exp_word); end
        @(negedge clk);
        s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rand_end_valid got %0b want 0", m_if.tvalid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        s_if.tvalid = 1'b1; s_if.tdata = mk_beat(300); s_if.tlast = 12'h000; m_if.tready = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        repeat (6) @(negedge clk);
        m_if.tready = 1'b0;
        #1;
        n_checks++;
        if (m_if.tdata !== 128'(306)) begin n_fail++; $display("FAIL midrst_lane6 got %0h want %0h", m_if.tdata, 306); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid got %0b want 0", m_if.tvalid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async_busy got %0b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_if.tvalid = 1'b1; s_if.tdata = mk_beat(400); s_if.tlast = 12'h004; m_if.tready = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 128'(400 + i)) begin
                n_fail++; $display("FAIL midrst_data beat %0d got valid %0b data %0h want valid 1 data %0h", i, m_if.tvalid, m_if.tdata, 400 + i);
            end
            n_checks++;
            if (m_if.tlast !== (i == 2)) begin n_fail++; $display("FAIL midrst_tlast beat %0d got %0b want %0b", i, m_if.tlast, i == 2); end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got tvalid %0b want 0", m_if.tvalid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_no_last();
        test_stop_lane(12'h010);
        test_stop_lane(12'h030);
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
